mealy_robot_ctrl: RTL and testbench
===================================

# mealy_robot_ctrl

Mealy-type controller for a wall-following robot (`mealy_robot`). Each cycle it reads two obstacle sensors, `head` (obstacle ahead) and `left` (wall on the left). It drives exactly one of two one-hot motion commands: move forward or rotate (fixed turn direction, toward the right). It sits between the sensor front-end and the motor sequencer, and its outputs depend combinationally on the current state and the current inputs.

## Interface
- Parameters: none.
- `clk`  in  1  system clock; state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; forces state to SEARCH.
- `head`  in  1  1 = obstacle directly in front.
- `left`  in  1  1 = wall present on the left side.
- `front`  out  1  command: advance one step (Mealy, combinational).
- `rotate`  out  1  command: rotate in place one step (Mealy, combinational).
- `state`  out  2  current state register, for debug and observability.
- One clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- State encoding:
  - SEARCH=2'b00 (looking for a wall)
  - FOLLOW=2'b01 (tracking the wall on the left)
  - ROTATE=2'b10 (turning away from a frontal obstacle)
  - 2'b11 is illegal.
- Transition and output rules, written as state, {head,left} -> output, next state:
  - SEARCH:
    - 00 -> front, SEARCH
    - 01 -> front, FOLLOW
    - 10 or 11 -> rotate, ROTATE
  - FOLLOW:
    - 01 -> front, FOLLOW
    - 00 -> front, SEARCH (wall lost)
    - 10 or 11 -> rotate, ROTATE
  - ROTATE:
    - 10 or 11 -> rotate, ROTATE
    - 01 -> front, FOLLOW
    - 00 -> front, SEARCH
  - Illegal 2'b11: outputs as SEARCH for the same inputs; next state SEARCH.
- Output invariant: exactly one of `front` and `rotate` is 1 at all times, in every state including the illegal one. {front,rotate} is never 00 or 11.
- `head`=1 always yields `rotate`=1, regardless of state or `left`.
- `head`=0 always yields `front`=1. The state only selects which state comes next.
- Outputs are pure combinational functions of (`state`, `head`, `left`); no output register.

## Timing
- Outputs respond within the same cycle to input changes; there is no latency between inputs and command.
- The state register updates on the `clk` rising edge using the `head`/`left` values sampled at that edge.
- Reset:
  - `rst_n`=0 asynchronously sets `state` to SEARCH, independent of `clk`.
  - While in reset, outputs follow the SEARCH row: `front`=~`head`, `rotate`=`head`.
  - Release is synchronous-safe; the first transition occurs on the first rising edge with `rst_n`=1.
- Reset asserted mid-operation, in any state: immediate return to SEARCH, with outputs updated in the same delta.
- Inputs are assumed stable around the rising edge. No internal synchronizer; the upstream block provides synchronous sensor signals.

## Test plan
- Reset then search:
  - Stimulus: `rst_n`=0, then release; apply {head,left}=00 for 2 cycles.
  - Required: `state`=00 throughout and `front`=1, `rotate`=0 each cycle.
- Obstacle while searching:
  - Stimulus: from SEARCH apply 10, then 00, then 00.
  - Required: first cycle `rotate`=1 and state becomes ROTATE. Second cycle `front`=1 and state becomes SEARCH. Third cycle `front`=1 and state stays SEARCH.
- Acquire and follow wall:
  - Stimulus: from SEARCH apply 01 for 4 cycles.
  - Required: `front`=1 every cycle; state becomes FOLLOW after the first edge and holds.
- Corner while following:
  - Stimulus: from FOLLOW apply 11, 10, 00, 01, 10.
  - Required outputs in order: rotate, rotate, front, front, rotate.
  - Required state sequence: ROTATE, ROTATE, SEARCH, FOLLOW, ROTATE.
- Asynchronous reset:
  - Stimulus: while in ROTATE with 10 applied, drop `rst_n` between clock edges.
  - Required: `state` becomes 00 immediately with no clock edge, `rotate` stays 1 (SEARCH row), and the next edge after release goes to ROTATE.
- Invariant check:
  - Stimulus: random {head,left} for ≥1000 cycles with random resets.
  - Required: `front`^`rotate`==1 on every cycle, and `state` is never 2'b11.

Source files
------------

// File: rtl/mealy_robot_ctrl.sv
//-----------------------------------------------------------------------------
// mealy_robot_ctrl
//
// Mealy controller for a wall-following robot. Each cycle it reads the two
// obstacle sensors and issues exactly one motion command: advance one step or
// rotate in place one step (fixed turn direction, toward the right). The
// commands are combinational in the current state and current sensor inputs.
// The state only selects where the controller goes next.
//
// Ports
//   clk     in   1  system clock; state updates on the rising edge
//   rst_n   in   1  asynchronous active-low reset; forces state to SEARCH
//   head    in   1  1 = obstacle directly in front
//   left    in   1  1 = wall present on the left side
//   front   out  1  command: advance one step (combinational)
//   rotate  out  1  command: rotate in place one step (combinational)
//   state   out  2  current state register, for debug/observability
//
// State encoding
//   SEARCH = 2'b00  looking for a wall
//   FOLLOW = 2'b01  tracking the wall on the left
//   ROTATE = 2'b10  turning away from a frontal obstacle
//   2'b11           illegal: behaves as SEARCH for outputs, recovers to SEARCH
//-----------------------------------------------------------------------------
module mealy_robot_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       head,
   input  logic       left,
   output logic       front,
   output logic       rotate,
   output logic [1:0] state
);

   localparam logic [1:0] SEARCH = 2'b00;
   localparam logic [1:0] FOLLOW = 2'b01;
   localparam logic [1:0] ROTATE = 2'b10;

   logic [1:0] state_q;
   logic [1:0] state_nxt;
   logic       front_c;
   logic       rotate_c;
   logic [1:0] sense;

   assign sense = {head, left};

   // Command decode. Every branch drives exactly one of the two commands, so
   // {front,rotate} is always one-hot, including in the illegal encoding and
   // while reset holds the register at SEARCH.
   always_comb begin
      front_c  = 1'b1;
      rotate_c = 1'b0;
      case (state_q)
         SEARCH, FOLLOW, ROTATE: begin
            if (head) begin
               front_c  = 1'b0;
               rotate_c = 1'b1;
            end else begin
               front_c  = 1'b1;
               rotate_c = 1'b0;
            end
         end
         default: begin
            // Illegal state mirrors the SEARCH row.
            front_c  = ~head;
            rotate_c = head;
         end
      endcase
   end

   // Next-state decode.
   always_comb begin
      state_nxt = SEARCH;
      case (state_q)
         SEARCH: begin
            case (sense)
               2'b00:   state_nxt = SEARCH;
               2'b01:   state_nxt = FOLLOW;
               default: state_nxt = ROTATE;
            endcase
         end
         FOLLOW: begin
            case (sense)
               2'b01:   state_nxt = FOLLOW;
               2'b00:   state_nxt = SEARCH;   // wall lost
               default: state_nxt = ROTATE;
            endcase
         end
         ROTATE: begin
            case (sense)
               2'b01:   state_nxt = FOLLOW;
               2'b00:   state_nxt = SEARCH;
               default: state_nxt = ROTATE;   // keep turning while blocked
            endcase
         end
         default: state_nxt = SEARCH;          // recover from illegal encoding
      endcase
   end

   // State register: asynchronous return to SEARCH so the outputs switch to
   // the SEARCH row immediately when reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEARCH;
      end else begin
         state_q <= state_nxt;
      end
   end

   assign front  = front_c;
   assign rotate = rotate_c;
   assign state  = state_q;

endmodule

// File: tb/tb_mealy_robot_ctrl.sv
module tb_mealy_robot_ctrl;

   logic       clk;
   logic       rst_n;
   logic       head;
   logic       left;
   logic       front;
   logic       rotate;
   logic [1:0] state;

   int n_cmp;
   int n_bad;

   // Reference model: transition and command tables transcribed from the
   // behaviour rules, indexed [state][{head,left}].
   int nxt_tab [0:2][0:3];
   int rot_tab [0:2][0:3];
   int mstate;

   mealy_robot_ctrl dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .head   (head),
      .left   (left),
      .front  (front),
      .rotate (rotate),
      .state  (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Compare combinational outputs and state against the model.
   task automatic check_now(input string tag);
      int hl;
      logic exp_rot;
      hl = {30'd0, head, left};
      exp_rot = rot_tab[mstate][hl][0];
      check({tag, "_cmd"}, {front, rotate}, {~exp_rot, exp_rot});
      check({tag, "_state"}, state, mstate[1:0]);
   endtask

   // One cycle: drive at negedge, check outputs, clock, check new state.
   task automatic step(input string tag, input logic h, input logic l);
      @(negedge clk);
      head = h;
      left = l;
      #1;
      check_now(tag);
      @(posedge clk);
      if (rst_n) mstate = nxt_tab[mstate][{30'd0, h, l}];
      #1;
      check({tag, "_next"}, state, mstate[1:0]);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      // SEARCH=0: 00->S, 01->F, 1x->R
      nxt_tab[0][0] = 0; nxt_tab[0][1] = 1; nxt_tab[0][2] = 2; nxt_tab[0][3] = 2;
      // FOLLOW=1: 00->S, 01->F, 1x->R
      nxt_tab[1][0] = 0; nxt_tab[1][1] = 1; nxt_tab[1][2] = 2; nxt_tab[1][3] = 2;
      // ROTATE=2: 00->S, 01->F, 1x->R
      nxt_tab[2][0] = 0; nxt_tab[2][1] = 1; nxt_tab[2][2] = 2; nxt_tab[2][3] = 2;
      for (int s = 0; s < 3; s++) begin
         rot_tab[s][0] = 0; rot_tab[s][1] = 0; rot_tab[s][2] = 1; rot_tab[s][3] = 1;
      end

      // Reset then search
      rst_n  = 1'b0;
      head   = 1'b0;
      left   = 1'b0;
      mstate = 0;
      #1;
      check_now("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      step("search0", 1'b0, 1'b0);
      step("search1", 1'b0, 1'b0);

      // Obstacle while searching
      step("obst_10", 1'b1, 1'b0);
      check("obst_in_rotate", state, 2'b10);
      step("obst_00a", 1'b0, 1'b0);
      check("obst_back_search", state, 2'b00);
      step("obst_00b", 1'b0, 1'b0);

      // Acquire and follow wall
      for (int i = 0; i < 4; i++) step("follow", 1'b0, 1'b1);
      check("follow_held", state, 2'b01);

      // Corner while following
      step("corner_11", 1'b1, 1'b1);
      step("corner_10", 1'b1, 1'b0);
      step("corner_00", 1'b0, 1'b0);
      step("corner_01", 1'b0, 1'b1);
      step("corner_10b", 1'b1, 1'b0);
      check("corner_end_rotate", state, 2'b10);

      // Asynchronous reset between edges while in ROTATE with 10 applied
      @(negedge clk);
      head = 1'b1;
      left = 1'b0;
      #2;
      rst_n  = 1'b0;
      mstate = 0;
      #1;
      check("async_state", state, 2'b00);
      check("async_cmd", {front, rotate}, 2'b01);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      mstate = nxt_tab[mstate][2];
      #1;
      check("async_release", state, 2'b10);

      // Randomized run with occasional resets
      for (int c = 0; c < 1200; c++) begin
         logic h, l, r;
         h = 1'($urandom_range(0, 1));
         l = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 39) != 0);
         @(negedge clk);
         head  = h;
         left  = l;
         rst_n = r;
         if (!r) mstate = 0;
         #1;
         check_now("rand");
         check("rand_onehot", {1'b0, front ^ rotate}, 2'b01);
         check("rand_legal", {1'b0, state == 2'b11}, 2'b00);
         @(posedge clk);
         if (r) mstate = nxt_tab[mstate][{30'd0, h, l}];
         #1;
         check("rand_next", state, mstate[1:0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
